alu_acc_seq: RTL

Command-driven accumulator that sits in front of the combinational ALU and acts as its initiator.
- Accepts a valid/ready stream of {op, operand, last} commands and folds each operand into an internal accumulator through the ALU.
- On the command marked last, registers the final value with neg/pos/zero flags, a sticky signed-overflow flag and a command count, then presents them on a valid/ready result port.
- Used by datapath test harnesses and sequencers that need multi-step ALU reductions without cycle-by-cycle control.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_core.sv | 31 +++
 rtl/alu_acc_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pkg : ALU operation/state encodings and signed-overflow helper
// Rev 1.0
// ----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    ADD_SEL = 2'b00,
    SUB_SEL = 2'b01,
    AND_SEL = 2'b10,
    OR_SEL  = 2'b11
  } alu_sel_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Only the sign bits matter, so this stays independent of WIDTH.
  function automatic logic ovf_detect(input alu_sel_t sel,
                                      input logic     a_msb,
                                      input logic     b_msb,
                                      input logic     r_msb);
    logic ovf;
    ovf = 1'b0;
    case (sel)
      ADD_SEL: ovf = (a_msb == b_msb) && (r_msb != a_msb);
      SUB_SEL: ovf = (a_msb != b_msb) && (r_msb != a_msb);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_core : combinational ALU, in0 <op> in1 with signed-overflow flag
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  alu_sel_t         sel_i,
  output logic [WIDTH-1:0] out_o,
  output logic             ovf_o
);

  always_comb begin
    out_o = '0;
    case (sel_i)
      ADD_SEL: out_o = in0_i + in1_i;
      SUB_SEL: out_o = in0_i - in1_i;
      AND_SEL: out_o = in0_i & in1_i;
      OR_SEL:  out_o = in0_i | in1_i;
      default: out_o = '0;
    endcase
    ovf_o = ovf_detect(sel_i, in0_i[WIDTH-1], in1_i[WIDTH-1], out_o[WIDTH-1]);
  end

endmodule
`default_nettype wire

// File: rtl/alu_acc_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_acc_seq : command-driven ALU accumulator with valid/ready result port
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  alu_sel_t         cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic             cmd_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_neg,
  output logic             res_pos,
  output logic             res_zero,
  output logic             res_ovf,
  output logic [CNT_W-1:0] res_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  acc_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_ovf_q, res_ovf_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;

  logic [WIDTH-1:0] alu_out;
  logic             alu_ovf;
  logic             accept;
  logic             step_ovf;
  logic [CNT_W-1:0] cnt_next;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .in0_i (acc_q),
    .in1_i (cmd_operand),
    .sel_i (cmd_op),
    .out_o (alu_out),
    .ovf_o (alu_ovf)
  );

  assign cmd_ready = (state_q == ACCUM);
  assign accept    = cmd_valid && cmd_ready;
  assign step_ovf  = sticky_q | alu_ovf;
  assign cnt_next  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_count_d = res_count_q;
    res_valid   = 1'b0;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cmd_last) begin
            // Publish the folded result and start the next sequence clean.
            res_data_d  = alu_out;
            res_ovf_d   = step_ovf;
            res_count_d = cnt_next;
            acc_d       = '0;
            sticky_d    = 1'b0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d    = alu_out;
            sticky_d = step_ovf;
            cnt_d    = cnt_next;
          end
        end
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_count_q <= res_count_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_count = res_count_q;
  assign res_zero  = (res_data_q == '0);
  assign res_neg   = !res_zero && res_data_q[WIDTH-1];
  assign res_pos   = !res_zero && !res_data_q[WIDTH-1];

endmodule
`default_nettype wire
